hilo_unit: RTL and testbench
============================

# hilo_unit

- Owns the HI/LO register pair for the MIPS pipeline.
- Sits after the ALU in EX and is the consumer of the ALU's 64-bit product (`result`/`result_h`).
- Handles MULT/MULTU by capturing the product, MTHI/MTLO by direct write, and DIV/DIVU with a 33-cycle iterative divider.
- Presents HI/LO to the pipeline for MFHI/MFLO and stalls the pipeline while a divide is in flight.

## Interface
- `WIDTH`, 32, datapath width; HI and LO are each `WIDTH` bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: EX-stage HI/LO operation present.
- `req_funct` in 6: funct code. MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
- `opa` in WIDTH: rs value; dividend, or write data for MTHI/MTLO.
- `opb` in WIDTH: rt value; divisor.
- `prod_lo` in WIDTH: ALU `result` for the same MULT/MULTU.
- `prod_hi` in WIDTH: ALU `result_h` for the same MULT/MULTU.
- `req_ready` out 1: request is accepted when `req_valid & req_ready`.
- `busy` out 1: divide in progress; pipeline must stall MFHI/MFLO and further HI/LO operations.
- `hi` out WIDTH: HI register, for MFHI.
- `lo` out WIDTH: LO register, for MFLO.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `req_ready`=1, FSM in IDLE.
- Request acceptance:
  - `req_ready` = ~`busy`; requests are accepted only in IDLE.
  - Any funct not listed above, including HALT 111111, is ignored with no state change.
- MULT/MULTU: on the accept edge, `hi`←`prod_hi` and `lo`←`prod_lo`. The unit does no multiply of its own; signedness is already resolved by the ALU.
- MTHI: `hi`←`opa`, `lo` unchanged. MTLO: `lo`←`opa`, `hi` unchanged.
- DIV/DIVU: restoring shift-subtract divide on magnitudes.
  - DIV takes |opa| and |opb| as unsigned WIDTH-bit values.
  - Operands, signs and op kind are latched at accept; the input ports are don't-care afterwards.
- FSM:
  - IDLE → DIV on a divide accept; the iteration counter is cleared to 0.
  - DIV performs one quotient bit per cycle, counter 0..WIDTH-1, then → FIN.
  - FIN applies sign fix-up and writes `hi`/`lo` on its edge, then → IDLE.
- Signed result rules:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero, both DIV and DIVU:
  - Full latency is still taken.
  - Result is `lo`=0xFFFFFFFF, `hi`=original `opa`, with no sign fix.
- `hi`/`lo` keep their old values throughout DIV/FIN. Reads during `busy` return stale data by design; the hazard unit stalls on `busy`.

## Timing
- MULT/MULTU/MTHI/MTLO: accepted in cycle N; new `hi`/`lo` visible from cycle N+1.
- Divide accepted in cycle N:
  - `busy`=1 for cycles N+1 through N+33 (WIDTH DIV cycles plus 1 FIN cycle).
  - `hi`/`lo` are updated on the edge ending cycle N+33.
  - `busy`=0 and the new values are visible from N+34.
  - The next request can be accepted in N+34.
- A `req_valid` held high while `busy`=1 is not consumed. The requester holds the request until it is accepted.
- Back-to-back non-divide ops are accepted every cycle; the later op wins on each register.
- `rst_n` low mid-divide:
  - Aborts immediately.
  - `hi`=`lo`=0, `busy`=0 asynchronously.
  - No partial result is written.

## Structure
- `mips_pkg` holds:
  - Funct localparams, shared with the ALU and the decoder; MULT/MULTU values must match the ALU's.
  - The FSM enum `hilo_state_t` {IDLE, DIV, FIN}.
- One sub-module, `hilo_divider`:
  - Contains the unsigned restoring core, counter and partial remainder.
  - Start/done handshake with magnitude inputs and quotient/remainder outputs.
- `hilo_unit` keeps the HI/LO registers, the sign handling and the request decode.

## Test plan
- MULT accept with `prod_hi`=0xFFFFFFFF, `prod_lo`=0xFFFFFFFA (−3×2) → next cycle `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; `busy` stays 0.
- DIVU 100/7 accepted at N → `busy` high N+1..N+33; from N+34 `lo`=14, `hi`=2.
- DIV −7/2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIV 7/−2 → `lo`=−3, `hi`=1. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- DIVU 5/0 → after 33 busy cycles `lo`=0xFFFFFFFF, `hi`=5.
- MTLO 0x1234 is held while `busy` → not accepted until `busy` falls; written the cycle after acceptance. MTHI and MTLO back-to-back → both applied, `hi`/`lo` independent.
- Assert `rst_n`=0 at DIV iteration 10 → `busy`, `hi`, `lo` go to 0 at once. After release, a fresh DIVU 9/3 gives `lo`=3, `hi`=0 with full latency.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes used by the decoder, ALU and HI/LO unit,
// plus the HI/LO FSM state type and a small funct decoder.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } hilo_state_t;

  typedef struct packed {
    logic is_mult;
    logic is_div;
    logic is_signed;
    logic wr_hi;
    logic wr_lo;
  } hilo_op_t;

  // Anything not recognised decodes to all-zero, i.e. a no-op for HI/LO.
  function automatic hilo_op_t decode_funct(input logic [5:0] funct);
    hilo_op_t op;
    op = '0;
    case (funct)
      FUNCT_MULT: begin
        op.is_mult   = 1'b1;
        op.is_signed = 1'b1;
      end
      FUNCT_MULTU: op.is_mult = 1'b1;
      FUNCT_DIV: begin
        op.is_div    = 1'b1;
        op.is_signed = 1'b1;
      end
      FUNCT_DIVU: op.is_div = 1'b1;
      FUNCT_MTHI: op.wr_hi  = 1'b1;
      FUNCT_MTLO: op.wr_lo  = 1'b1;
      default:    op        = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses on the last step.
// WIDTH cycles after start; start is only honoured while idle by the caller.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             running;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, dsr_q});
    rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;
    done      = running && (count == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      quo_q   <= dividend;
      rem_q   <= '0;
      dsr_q   <= divisor;
    end else if (running) begin
      quo_q <= {quo_q[WIDTH-2:0], fits};
      rem_q <= fits ? rem_sub : rem_shift[WIDTH-1:0];
      count <= count + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair: MULT/MTHI/MTLO write next cycle, DIV/DIVU take WIDTH+1 busy cycles.
// req_ready drops while a divide is in flight; a held request is taken once busy clears.
module hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] prod_lo,
  input  logic [WIDTH-1:0] prod_hi,
  output logic             req_ready,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  hilo_state_t      state;
  hilo_state_t      state_nxt;
  hilo_op_t         op;
  logic             accept;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  logic             q_neg_q;
  logic             r_neg_q;
  logic             zero_q;
  logic [WIDTH-1:0] opa_q;

  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  always_comb begin
    op        = decode_funct(req_funct);
    accept    = req_valid && req_ready;
    div_start = accept && op.is_div;
    mag_a     = (op.is_signed && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    mag_b     = (op.is_signed && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
  end

  hilo_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Everything needed for the fix-up is captured at accept so the request
  // ports are free to change for the rest of the divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      opa_q   <= '0;
    end else if (div_start) begin
      q_neg_q <= op.is_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
      r_neg_q <= op.is_signed && opa[WIDTH-1];
      zero_q  <= (opb == '0);
      opa_q   <= opa;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (div_start) state_nxt = DIV;
      DIV:     if (div_done)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    req_ready = ~busy;
    q_fix     = q_neg_q ? (~quotient + 1'b1) : quotient;
    r_fix     = r_neg_q ? (~remainder + 1'b1) : remainder;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi;
    lo_d      = lo;
    case (state)
      IDLE: begin
        if (accept && op.is_mult) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = prod_hi;
          lo_d  = prod_lo;
        end
        if (accept && op.wr_hi) begin
          hi_we = 1'b1;
          hi_d  = opa;
        end
        if (accept && op.wr_lo) begin
          lo_we = 1'b1;
          lo_d  = opa;
        end
      end
      FIN: begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        hi_d  = zero_q ? opa_q : r_fix;
        lo_d  = zero_q ? '1    : q_fix;
      end
      default: begin
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed plus random checks of hilo_unit against an arithmetic HI/LO model.
module tb_hilo_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_funct;
  logic [31:0] opa, opb, prod_lo, prod_hi;
  logic        req_ready, busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] mhi, mlo;

  hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_funct(req_funct),
    .opa(opa), .opb(opb), .prod_lo(prod_lo), .prod_hi(prod_hi),
    .req_ready(req_ready), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge, then scrambles the operand ports.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ph, input logic [31:0] pl);
    req_valid = 1'b1;
    req_funct = f;
    opa = a; opb = b; prod_hi = ph; prod_lo = pl;
    step();
    req_valid = 1'b0;
    opa = $urandom; opb = $urandom; prod_hi = $urandom; prod_lo = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  // MIPS divide semantics from plain integer arithmetic.
  task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  task automatic do_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] eh, el;
    issue(sgn ? FUNCT_DIV : FUNCT_DIVU, a, b, 32'h0, 32'h0);
    check({tag, "_busy_first"}, {31'b0, busy}, 32'd1);
    check({tag, "_hi_stale"}, hi, mhi);
    check({tag, "_lo_stale"}, lo, mlo);
    wait_idle(n);
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    model_div(sgn, a, b, eh, el);
    check({tag, "_lo"}, lo, el);
    check({tag, "_hi"}, hi, eh);
    mhi = eh;
    mlo = el;
  endtask

  initial begin
    int n;
    logic [5:0]  f;
    logic [31:0] a, b, ph, pl;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_funct = 6'd0;
    opa = 0; opb = 0; prod_lo = 0; prod_hi = 0;
    mhi = 0; mlo = 0;
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    #3 rst_n = 1'b1;
    step();

    issue(FUNCT_MULT, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_busy", {31'b0, busy}, 32'd0);
    mhi = 32'hFFFF_FFFF; mlo = 32'hFFFF_FFFA;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    check("divu_100_7_const_lo", lo, 32'd14);
    check("divu_100_7_const_hi", hi, 32'd2);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_const_lo", lo, 32'hFFFF_FFFD);
    check("div_m7_2_const_hi", hi, 32'hFFFF_FFFF);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_const_lo", lo, 32'hFFFF_FFFD);
    check("div_7_m2_const_hi", hi, 32'd1);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_const_lo", lo, 32'h8000_0000);
    check("div_min_m1_const_hi", hi, 32'd0);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    check("divu_5_0_const_lo", lo, 32'hFFFF_FFFF);
    check("divu_5_0_const_hi", hi, 32'd5);
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    check("div_m5_0_const_hi", hi, 32'hFFFF_FFFB);

    issue(FUNCT_HALT, 32'hDEAD_BEEF, 32'h1, 32'h1111, 32'h2222);
    check("halt_hi", hi, mhi);
    check("halt_lo", lo, mlo);
    check("halt_busy", {31'b0, busy}, 32'd0);

    // MTLO held high across a divide must wait for busy to fall.
    issue(FUNCT_DIVU, 32'd50, 32'd6, 32'h0, 32'h0);
    req_valid = 1'b1; req_funct = FUNCT_MTLO; opa = 32'h1234;
    check("held_ready_low", {31'b0, req_ready}, 32'd0);
    wait_idle(n);
    check("held_busy_cycles", 32'(n), 32'd33);
    check("held_lo_div", lo, 32'd8);
    check("held_hi_div", hi, 32'd2);
    step();
    req_valid = 1'b0;
    check("held_lo_mtlo", lo, 32'h1234);
    check("held_hi_keep", hi, 32'd2);

    req_valid = 1'b1; req_funct = FUNCT_MTHI; opa = 32'hAAAA_0001;
    step();
    req_funct = FUNCT_MTLO; opa = 32'h5555_0002;
    step();
    req_valid = 1'b0;
    check("b2b_hi", hi, 32'hAAAA_0001);
    check("b2b_lo", lo, 32'h5555_0002);

    issue(FUNCT_DIV, 32'd1000, 32'd3, 32'h0, 32'h0);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    #3 rst_n = 1'b1;
    mhi = 0; mlo = 0;
    step();
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3);
    check("divu_9_3_const_lo", lo, 32'd3);
    check("divu_9_3_const_hi", hi, 32'd0);

    for (int i = 0; i < 60; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      ph = $urandom; pl = $urandom;
      case ($urandom_range(0, 9))
        0: f = FUNCT_MULT;
        1: f = FUNCT_MULTU;
        2, 3: f = FUNCT_DIV;
        4, 5: f = FUNCT_DIVU;
        6: f = FUNCT_MTHI;
        7: f = FUNCT_MTLO;
        8: f = FUNCT_MFHI;
        default: f = FUNCT_HALT;
      endcase
      if (f == FUNCT_DIV || f == FUNCT_DIVU) begin
        do_div($sformatf("rnd%0d_div", i), f == FUNCT_DIV, a, b);
      end else begin
        issue(f, a, b, ph, pl);
        if (f == FUNCT_MULT || f == FUNCT_MULTU) begin
          mhi = ph; mlo = pl;
        end else if (f == FUNCT_MTHI) begin
          mhi = a;
        end else if (f == FUNCT_MTLO) begin
          mlo = a;
        end
        check($sformatf("rnd%0d_hi", i), hi, mhi);
        check($sformatf("rnd%0d_lo", i), lo, mlo);
        check($sformatf("rnd%0d_busy", i), {31'b0, busy}, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
